// File: rtl/seq_packet_parser.sv
// Streaming parser: strips an 8-byte little-endian header from a 32-bit word stream,
// emits up to 37 payload bytes as one wide word and flags per-stream sequence gaps.
module seq_packet_parser #(
    parameter int NUM_STREAMS = 16,
    parameter int MAX_LEN     = 45
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [31:0]  dataIn,
    input  logic         dataIn_val,
    output logic         dataIn_ready,
    input  logic         dataIN_last,
    output logic [0:295] dataOut,
    output logic         dataOut_val,
    input  logic         dataOut_ready,
    output logic         packetLost,
    output logic [1:0]   state_dbg
);
    localparam int PAY_BYTES = 37;
    localparam int IDX_W     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [1:0] {
        HDR0    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } state_t;

    // Handshake: a word moves when dataIn_val && dataIn_ready; a result moves when
    // dataOut_val && dataOut_ready. Input stalls only while a result is stuck.
    state_t       state, state_nxt;
    logic         accept, complete, lost;
    logic [15:0]  hdr_len, hdr_sid;
    logic [31:0]  hdr_seq, seq_cur;
    logic         len_bad;
    logic [5:0]   pay_len_q;
    logic [3:0]   last_idx_q, widx_q, pay_word;
    logic [15:0]  sid_q;
    logic [31:0]  seq_q;
    logic [0:295] stage_q, stage_nxt;
    logic [IDX_W-1:0] tbl_idx;

    logic         tbl_valid [NUM_STREAMS];
    logic [15:0]  tbl_tag   [NUM_STREAMS];
    logic [31:0]  tbl_seq   [NUM_STREAMS];

    assign dataIn_ready = !dataOut_val || dataOut_ready;
    assign accept       = dataIn_val && dataIn_ready;
    assign state_dbg    = state;

    assign hdr_len = {dataIn[23:16], dataIn[31:24]};
    assign hdr_sid = {dataIn[7:0], dataIn[15:8]};
    assign hdr_seq = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
    assign len_bad = (hdr_len < 16'd8) || (hdr_len > 16'(MAX_LEN));

    // A header-only message completes while still in HDR1, before seq_q is loaded.
    assign seq_cur  = (state == HDR1) ? hdr_seq : seq_q;
    assign tbl_idx  = IDX_W'(sid_q % 16'(NUM_STREAMS));
    assign lost     = tbl_valid[tbl_idx] && (tbl_tag[tbl_idx] == sid_q) &&
                      (seq_cur != tbl_seq[tbl_idx] + 32'd1);
    assign pay_word = widx_q - 4'd2;

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        if (accept) begin
            case (state)
                HDR0: begin
                    if (dataIN_last)  state_nxt = HDR0;
                    else if (len_bad) state_nxt = DISCARD;
                    else              state_nxt = HDR1;
                end
                HDR1, PAYLOAD: begin
                    if (dataIN_last) begin
                        complete  = (widx_q == last_idx_q);
                        state_nxt = HDR0;
                    end else if (widx_q == last_idx_q) begin
                        state_nxt = DISCARD;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
                default: begin
                    if (dataIN_last) state_nxt = HDR0;
                end
            endcase
        end
    end

    // Merge the current payload word; bytes past msgLen are padding and stay zero.
    always_comb begin
        stage_nxt = stage_q;
        if (state == PAYLOAD) begin
            for (int k = 0; k < PAY_BYTES; k++) begin
                if (((k >> 2) == int'(pay_word)) && (k < int'(pay_len_q))) begin
                    stage_nxt[8*k +: 8] = dataIn[31 - 8*(k % 4) -: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= HDR0;
            pay_len_q  <= '0;
            last_idx_q <= '0;
            widx_q     <= '0;
            sid_q      <= '0;
            seq_q      <= '0;
            stage_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (state == HDR0) begin
                    stage_q    <= '0;
                    sid_q      <= hdr_sid;
                    pay_len_q  <= hdr_len[5:0] - 6'd8;
                    last_idx_q <= 4'((hdr_len[5:0] - 6'd1) >> 2);
                    widx_q     <= 4'd1;
                end else begin
                    stage_q <= stage_nxt;
                    widx_q  <= widx_q + 4'd1;
                end
                if (state == HDR1) seq_q <= hdr_seq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dataOut     <= '0;
            dataOut_val <= 1'b0;
            packetLost  <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_tag[i]   <= '0;
                tbl_seq[i]   <= '0;
            end
        end else begin
            if (complete) begin
                dataOut            <= stage_nxt;
                dataOut_val        <= 1'b1;
                packetLost         <= lost;
                tbl_valid[tbl_idx] <= 1'b1;
                tbl_tag[tbl_idx]   <= sid_q;
                tbl_seq[tbl_idx]   <= seq_cur;
            end else if (dataOut_val && dataOut_ready) begin
                dataOut     <= '0;
                dataOut_val <= 1'b0;
                packetLost  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_packet_parser.sv
// Bench for seq_packet_parser: directed scenarios plus random traffic, checked against a
// byte-stream reference model with a per-stream sequence table and an expected queue.
module tb_seq_packet_parser;
    localparam int NUM_STREAMS = 16;
    localparam int MAX_LEN     = 45;

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic [31:0]  dataIn = '0;
    logic         dataIn_val = 1'b0;
    logic         dataIn_ready;
    logic         dataIN_last = 1'b0;
    logic [0:295] dataOut;
    logic         dataOut_val;
    logic         dataOut_ready = 1'b1;
    logic         packetLost;
    logic [1:0]   state_dbg;

    seq_packet_parser #(.NUM_STREAMS(NUM_STREAMS), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset_b(reset_b),
        .dataIn(dataIn), .dataIn_val(dataIn_val), .dataIn_ready(dataIn_ready),
        .dataIN_last(dataIN_last),
        .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
        .packetLost(packetLost), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [296:0] exp_q[$];
    logic         m_valid [NUM_STREAMS];
    logic [15:0]  m_tag   [NUM_STREAMS];
    logic [31:0]  m_seq   [NUM_STREAMS];
    logic [31:0]  nxt_seq [41];
    bit           bp_en  = 1'b0;
    bit           mon_en = 1'b0;

    task automatic chk(input string tag, input logic [296:0] obs, input logic [296:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sequence rule applied to a direct-mapped table of last-seen sequence numbers.
    function automatic logic model_seq(input logic [15:0] sid, input logic [31:0] seq);
        int   slot = int'(sid) % NUM_STREAMS;
        logic l    = m_valid[slot] && (m_tag[slot] == sid) && (seq != m_seq[slot] + 32'd1);
        m_valid[slot] = 1'b1;
        m_tag[slot]   = sid;
        m_seq[slot]   = seq;
        return l;
    endfunction

    // Monitor: checks each consumed result against the queue and that stalled results hold.
    logic [296:0] held;
    bit           held_v = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_val", 297'(dataOut_val), 297'd1);
                chk("hold_data", {packetLost, dataOut}, held);
            end
            held_v = 1'b0;
            if (dataOut_val) begin
                if (dataOut_ready) begin
                    chk("exp_avail", 297'(exp_q.size() != 0), 297'd1);
                    if (exp_q.size() != 0) chk("out", {packetLost, dataOut}, exp_q.pop_front());
                end else begin
                    held   = {packetLost, dataOut};
                    held_v = 1'b1;
                end
            end
        end
    end

    task automatic drive_word(input logic [31:0] w, input logic last);
        int guard = 0;
        bit done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bp_en) dataOut_ready = ($urandom_range(0, 3) != 0);
            dataIn      = w;
            dataIn_val  = 1'b1;
            dataIN_last = last;
            #1;
            if (dataIn_ready) begin
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    chk("in_ready_timeout", 297'(dataIn_ready), 297'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dataIn_val  = 1'b0;
            dataIN_last = 1'b0;
            dataIn      = $urandom;
            if (bp_en) dataOut_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // kind: 0 good, 1 bad length (arg words), 2 early last on word arg, 3 late last (arg extra words)
    task automatic send_msg(input int kind, input logic [15:0] sid, input logic [31:0] seq,
                            input int len, input int arg);
        logic [7:0]   bytes[$];
        logic [15:0]  l16 = 16'(len);
        logic [0:295] pay = '0;
        logic         lost;
        int           nw;
        bytes = {l16[7:0], l16[15:8], sid[7:0], sid[15:8],
                 seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
        case (kind)
            0:       nw = (len + 3) / 4;
            1:       nw = arg;
            2:       nw = arg + 1;
            default: nw = (len + 3) / 4 + arg;
        endcase
        while (bytes.size() < nw * 4) bytes.push_back(8'($urandom));
        if (kind == 0) begin
            for (int k = 0; k < len - 8; k++) pay[8*k +: 8] = bytes[8 + k];
            lost = model_seq(sid, seq);
            exp_q.push_back({lost, pay});
        end
        for (int i = 0; i < nw; i++)
            drive_word({bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]}, i == nw - 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en      = 1'b0;
        reset_b     = 1'b0;
        dataIn_val  = 1'b0;
        dataIN_last = 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) m_valid[i] = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dataOut", 297'(dataOut), 297'd0);
        chk("rst_val", 297'(dataOut_val), 297'd0);
        chk("rst_lost", 297'(packetLost), 297'd0);
        chk("rst_state", 297'(state_dbg), 297'd0);
        chk("rst_in_ready", 297'(dataIn_ready), 297'd1);
        @(negedge clk);
        reset_b = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sid;
        logic [31:0] seq;
        int          kind, len, arg, r;

        do_reset();

        // Scenario 1: fixed stream 12 message, exact payload.
        exp_q.push_back({model_seq(16'd12, 32'd0), 96'h0C001402_0C001403_0C001404, 200'd0});
        drive_word(32'h14000C00, 1'b0);
        drive_word(32'h00000000, 1'b0);
        drive_word(32'h0C001402, 1'b0);
        drive_word(32'h0C001403, 1'b0);
        drive_word(32'h0C001404, 1'b1);
        idle(2);

        // Scenario 2: gap on stream 14; scenario 3: full-length payload on stream 12.
        send_msg(0, 16'd14, 32'd0, 12, 0);
        send_msg(0, 16'd14, 32'd2, 23, 0);
        send_msg(0, 16'd12, 32'd1, 45, 0);
        send_msg(0, 16'd30, 32'd9, 8, 0);
        idle(3);

        // Scenario 4: stall the consumer, then release while the next message waits.
        @(negedge clk);
        dataOut_ready = 1'b0;
        send_msg(0, 16'd5, 32'd0, 16, 0);
        idle(1);
        #1;
        chk("stall_out_val", 297'(dataOut_val), 297'd1);
        chk("stall_in_ready", 297'(dataIn_ready), 297'd0);
        fork
            begin
                repeat (5) @(negedge clk);
                dataOut_ready = 1'b1;
            end
        join_none
        send_msg(0, 16'd6, 32'd0, 24, 0);
        send_msg(0, 16'd5, 32'd1, 13, 0);
        idle(3);

        // Scenario 5: late last drops the message and leaves the table at seq 5.
        send_msg(0, 16'd15, 32'd5, 44, 0);
        send_msg(3, 16'd15, 32'd6, 43, 1);
        send_msg(0, 16'd15, 32'd6, 20, 0);

        // Scenario 6: oversize, undersize and early-last messages are dropped.
        send_msg(1, 16'd20, 32'd0, 50, 3);
        send_msg(1, 16'd20, 32'd0, 7, 1);
        send_msg(2, 16'd21, 32'd0, 20, 1);
        send_msg(0, 16'd21, 32'd0, 16, 0);
        idle(3);

        // Reset in the middle of a message clears both parser and table.
        drive_word(32'h14000C00, 1'b0);
        drive_word(32'h09000000, 1'b0);
        do_reset();
        send_msg(0, 16'd12, 32'd9, 20, 0);
        idle(3);

        // Random traffic with consumer backpressure and aliasing stream IDs.
        for (int i = 0; i < 41; i++) nxt_seq[i] = $urandom;
        bp_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 9);
            sid = 16'($urandom_range(0, 40));
            seq = ($urandom_range(0, 3) == 0) ? 32'($urandom) : nxt_seq[sid];
            len = $urandom_range(8, MAX_LEN);
            arg = 0;
            if (r <= 6) begin
                kind = 0;
                nxt_seq[sid] = seq + 32'd1;
            end else if (r == 7) begin
                kind = 1;
                len  = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(MAX_LEN + 1, 1000);
                arg  = $urandom_range(1, 4);
            end else if (r == 8) begin
                kind = 2;
                arg  = $urandom_range(0, (len + 3) / 4 - 2);
            end else begin
                kind = 3;
                arg  = $urandom_range(1, 3);
            end
            send_msg(kind, sid, seq, len, arg);
            idle($urandom_range(0, 2));
        end

        bp_en = 1'b0;
        @(negedge clk);
        dataOut_ready = 1'b1;
        idle(10);
        chk("queue_drained", 297'(exp_q.size()), 297'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
